// File: rtl/arm_control_unit_if.sv
// Control bus between instruction memory, datapath and data-memory port
// for the ARM sequencing controller.
interface arm_control_unit_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;
  logic [1:0]  RegSrc;
  logic [1:0]  ImmSrc;
  logic        ALUSrc;
  logic [2:0]  ALUControl;
  logic        MemtoReg;
  logic        RegWrite;
  logic        MemWrite;
  logic        PCSrc;
  logic        MemReq;
  logic        PCWrite;
  logic        MemFault;
  logic [3:0]  Flags;

  modport master (
    output Instr, ALUFlags, MemReady,
    input  RegSrc, ImmSrc, ALUSrc, ALUControl, MemtoReg, RegWrite,
           MemWrite, PCSrc, MemReq, PCWrite, MemFault, Flags
  );

  modport slave (
    input  Instr, ALUFlags, MemReady,
    output RegSrc, ImmSrc, ALUSrc, ALUControl, MemtoReg, RegWrite,
           MemWrite, PCSrc, MemReq, PCWrite, MemFault, Flags
  );
endinterface

// File: rtl/arm_control_unit.sv
// Decoder, NZCV flag register and data-memory wait-state handshake for the
// single-cycle ARM datapath. Define CTRL_MEMWAIT_EN to enable the handshake.
module arm_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic clk,
  input logic reset,
  arm_control_unit_if.slave bus
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;
  logic [3:0] flagReg;
  logic       condPass;

  logic [1:0] regSrc;
  logic [1:0] immSrc;
  logic       aluSrc;
  logic [2:0] aluCtrl;
  logic       memtoReg;
  logic       rawRegWrite;
  logic       rawMemWrite;
  logic       rawBranch;
  logic       rawPcSrc;
  logic       memOp;
  logic       flagUpdate;
  logic       arithOp;
  logic       memOpEx;

  logic       stall;
  logic       timeout;
  logic       complete;

  assign cond  = bus.Instr[31:28];
  assign op    = bus.Instr[27:26];
  assign funct = bus.Instr[25:20];
  assign rd    = bus.Instr[15:12];
  assign cmd   = funct[4:1];

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_timeoutRange
    $error("MEM_TIMEOUT must lie in 1..255");
  end

  // Condition field evaluated against the architectural flags {N,Z,C,V}.
  always_comb begin
    condPass = 1'b0;
    case (cond)
      4'b0000: condPass = flagReg[2];
      4'b0001: condPass = ~flagReg[2];
      4'b0010: condPass = flagReg[1];
      4'b0011: condPass = ~flagReg[1];
      4'b0100: condPass = flagReg[3];
      4'b0101: condPass = ~flagReg[3];
      4'b0110: condPass = flagReg[0];
      4'b0111: condPass = ~flagReg[0];
      4'b1000: condPass = flagReg[1] & ~flagReg[2];
      4'b1001: condPass = ~flagReg[1] | flagReg[2];
      4'b1010: condPass = (flagReg[3] == flagReg[0]);
      4'b1011: condPass = (flagReg[3] != flagReg[0]);
      4'b1100: condPass = ~flagReg[2] & (flagReg[3] == flagReg[0]);
      4'b1101: condPass = flagReg[2] | (flagReg[3] != flagReg[0]);
      4'b1110: condPass = 1'b1;
      default: condPass = 1'b0;
    endcase
  end

  always_comb begin
    regSrc      = 2'b00;
    immSrc      = 2'b00;
    aluSrc      = 1'b0;
    aluCtrl     = 3'b000;
    memtoReg    = 1'b0;
    rawRegWrite = 1'b0;
    rawMemWrite = 1'b0;
    rawBranch   = 1'b0;
    memOp       = 1'b0;
    flagUpdate  = 1'b0;
    arithOp     = 1'b0;
    case (op)
      2'b00: begin
        aluSrc = funct[5];
        case (cmd)
          4'b0100: begin
            aluCtrl     = 3'b000;
            rawRegWrite = 1'b1;
            arithOp     = 1'b1;
            flagUpdate  = funct[0];
          end
          4'b0010: begin
            aluCtrl     = 3'b001;
            rawRegWrite = 1'b1;
            arithOp     = 1'b1;
            flagUpdate  = funct[0];
          end
          4'b0000: begin
            aluCtrl     = 3'b010;
            rawRegWrite = 1'b1;
            flagUpdate  = funct[0];
          end
          4'b1100: begin
            aluCtrl     = 3'b011;
            rawRegWrite = 1'b1;
            flagUpdate  = funct[0];
          end
          4'b1010: begin
            aluCtrl    = 3'b001;
            arithOp    = 1'b1;
            flagUpdate = 1'b1;
          end
          default: ;
        endcase
      end
      2'b01: begin
        immSrc  = 2'b01;
        aluSrc  = 1'b1;
        aluCtrl = funct[3] ? 3'b000 : 3'b001;
        memOp   = 1'b1;
        if (funct[0]) begin
          rawRegWrite = 1'b1;
          memtoReg    = 1'b1;
        end else begin
          regSrc      = 2'b10;
          rawMemWrite = 1'b1;
        end
      end
      2'b10: begin
        regSrc    = 2'b01;
        immSrc    = 2'b10;
        aluSrc    = 1'b1;
        rawBranch = 1'b1;
      end
      default: ;
    endcase
  end

  // A register write to R15 is a jump, whether from the ALU or a load.
  assign rawPcSrc = rawBranch | (rawRegWrite & (rd == 4'hF));
  assign memOpEx  = memOp & condPass;

`ifdef CTRL_MEMWAIT_EN
  typedef enum logic {EXEC, MEM_WAIT} state_t;

  state_t     state;
  logic [7:0] waitCount;

  // Timeout means the access is abandoned: the instruction retires without
  // writing anything, and the PC moves on.
  always_comb begin
    timeout  = (state == MEM_WAIT) && memOpEx && !bus.MemReady &&
               (waitCount == 8'(MEM_TIMEOUT));
    stall    = memOpEx && !bus.MemReady && !timeout;
    complete = !stall && !timeout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EXEC;
      waitCount <= 8'd0;
    end else begin
      case (state)
        EXEC: begin
          if (memOpEx && !bus.MemReady) begin
            state     <= MEM_WAIT;
            waitCount <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (!memOpEx || bus.MemReady || timeout) begin
            state     <= EXEC;
            waitCount <= 8'd0;
          end else begin
            waitCount <= waitCount + 8'd1;
          end
        end
        default: begin
          state     <= EXEC;
          waitCount <= 8'd0;
        end
      endcase
    end
  end

  assign bus.MemFault = !reset && timeout;
`else
  assign stall        = 1'b0;
  assign timeout      = 1'b0;
  assign complete     = 1'b1;
  assign bus.MemFault = 1'b0;
`endif

  assign bus.RegSrc     = regSrc;
  assign bus.ImmSrc     = immSrc;
  assign bus.ALUSrc     = aluSrc;
  assign bus.ALUControl = aluCtrl;
  assign bus.MemtoReg   = memtoReg;
  assign bus.RegWrite   = !reset && rawRegWrite && condPass && complete;
  assign bus.MemWrite   = !reset && rawMemWrite && condPass && !timeout;
  assign bus.PCSrc      = !reset && rawPcSrc && condPass && complete;
  assign bus.MemReq     = !reset && memOpEx && !timeout;
  assign bus.PCWrite    = !reset && !stall;
  assign bus.Flags      = flagReg;

  // Logical ops touch only N and Z; carry and overflow survive from before.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flagReg <= 4'b0000;
    end else if (flagUpdate && condPass && complete) begin
      flagReg[3:2] <= bus.ALUFlags[3:2];
      if (arithOp) begin
        flagReg[1:0] <= bus.ALUFlags[1:0];
      end
    end
  end

endmodule

// File: tb/tb_arm_control_unit.sv
// Scoreboard testbench for arm_control_unit; follows CTRL_MEMWAIT_EN so the
// same bench covers both the handshake build and the single-cycle build.
module tb_arm_control_unit;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  alu;
    logic        rdy;
    string       tag;
    logic [18:0] exp;
    logic [18:0] mask;
  } stim_t;

  typedef struct {
    string       tag;
    logic [18:0] exp;
    logic [18:0] mask;
  } exp_t;

  localparam logic [18:0] FULL    = 19'h7FFFF;
  localparam logic [18:0] NOMEMRQ = 19'h7FFBF;

  logic clk;
  logic reset;
  int   checks;
  int   fails;
  exp_t sb[$];

  arm_control_unit_if bus();

  arm_control_unit #(.MEM_TIMEOUT(15)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Field order: RegSrc ImmSrc ALUSrc ALUControl MemtoReg RegWrite MemWrite
  // PCSrc MemReq PCWrite MemFault Flags
  function automatic logic [18:0] cv(input logic [1:0] rs, input logic [1:0] is,
                                     input logic as, input logic [2:0] ac,
                                     input logic m2r, input logic rw, input logic mw,
                                     input logic pcs, input logic mr, input logic pw,
                                     input logic mf, input logic [3:0] fl);
    return {rs, is, as, ac, m2r, rw, mw, pcs, mr, pw, mf, fl};
  endfunction

  function automatic logic [18:0] actualVec();
    return {bus.RegSrc, bus.ImmSrc, bus.ALUSrc, bus.ALUControl, bus.MemtoReg,
            bus.RegWrite, bus.MemWrite, bus.PCSrc, bus.MemReq, bus.PCWrite,
            bus.MemFault, bus.Flags};
  endfunction

  function automatic stim_t mk(input logic [31:0] instr, input logic [3:0] alu,
                               input logic rdy, input string tag,
                               input logic [18:0] exp, input logic [18:0] mask);
    stim_t s;
    s.instr = instr;
    s.alu   = alu;
    s.rdy   = rdy;
    s.tag   = tag;
    s.exp   = exp;
    s.mask  = mask;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    bus.Instr    = s.instr;
    bus.ALUFlags = s.alu;
    bus.MemReady = s.rdy;
    e.tag  = s.tag;
    e.exp  = s.exp;
    e.mask = s.mask;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    stim_t steps[$];
    exp_t  e;
    logic [18:0] act;
    steps.push_back(mk(32'hE0810002, 4'hF, 1'b1, "reset_add",
                       cv(2'd0, 2'd0, 1'b0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 4'h0), FULL));
    steps.push_back(mk(32'hE5912004, 4'hF, 1'b0, "reset_ldr",
                       cv(2'd0, 2'd1, 1'b1, 3'd0, 1, 0, 0, 0, 0, 0, 0, 4'h0), FULL));
    steps.push_back(mk(32'hE5812000, 4'hF, 1'b0, "reset_str",
                       cv(2'd2, 2'd1, 1'b1, 3'd0, 0, 0, 0, 0, 0, 0, 0, 4'h0), FULL));
    foreach (steps[i]) begin
      applyStimulus(steps[i]);
      @(negedge clk);
      e   = sb.pop_front();
      act = actualVec();
      checks++;
      if ((act & e.mask) !== (e.exp & e.mask)) begin
        fails++;
        $display("[TB] FAIL %s: got %05h expected %05h", e.tag, act & e.mask, e.exp & e.mask);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_decode_flags();
    stim_t steps[$];
    exp_t  e;
    logic [18:0] act;
    steps.push_back(mk(32'hE0810002, 4'hF, 1'b0, "add",
                       cv(2'd0, 2'd0, 1'b0, 3'd0, 0, 1, 0, 0, 0, 1, 0, 4'h0), FULL));
    steps.push_back(mk(32'hE2510005, 4'h4, 1'b0, "subs",
                       cv(2'd0, 2'd0, 1'b1, 3'd1, 0, 1, 0, 0, 0, 1, 0, 4'h0), FULL));
    steps.push_back(mk(32'h0A000003, 4'h0, 1'b0, "beq_taken",
                       cv(2'd1, 2'd2, 1'b1, 3'd0, 0, 0, 0, 1, 0, 1, 0, 4'h4), FULL));
    steps.push_back(mk(32'h1A000003, 4'h0, 1'b0, "bne_skip",
                       cv(2'd1, 2'd2, 1'b1, 3'd0, 0, 0, 0, 0, 0, 1, 0, 4'h4), FULL));
    steps.push_back(mk(32'hE0110002, 4'hB, 1'b0, "ands",
                       cv(2'd0, 2'd0, 1'b0, 3'd2, 0, 1, 0, 0, 0, 1, 0, 4'h4), FULL));
    steps.push_back(mk(32'hE1810002, 4'h7, 1'b0, "orr_nz_only",
                       cv(2'd0, 2'd0, 1'b0, 3'd3, 0, 1, 0, 0, 0, 1, 0, 4'h8), FULL));
    steps.push_back(mk(32'hF0810002, 4'h0, 1'b0, "cond_never",
                       cv(2'd0, 2'd0, 1'b0, 3'd0, 0, 0, 0, 0, 0, 1, 0, 4'h8), FULL));
    steps.push_back(mk(32'hAA000003, 4'h0, 1'b0, "bge_skip",
                       cv(2'd1, 2'd2, 1'b1, 3'd0, 0, 0, 0, 0, 0, 1, 0, 4'h8), FULL));
    steps.push_back(mk(32'hBA000003, 4'h0, 1'b0, "blt_taken",
                       cv(2'd1, 2'd2, 1'b1, 3'd0, 0, 0, 0, 1, 0, 1, 0, 4'h8), FULL));
    steps.push_back(mk(32'hE3510000, 4'h6, 1'b0, "cmp",
                       cv(2'd0, 2'd0, 1'b1, 3'd1, 0, 0, 0, 0, 0, 1, 0, 4'h8), FULL));
    steps.push_back(mk(32'hE3A0F010, 4'h0, 1'b0, "mov_pc_nop",
                       cv(2'd0, 2'd0, 1'b1, 3'd0, 0, 0, 0, 0, 0, 1, 0, 4'h6), FULL));
    steps.push_back(mk(32'hE280F004, 4'h0, 1'b0, "add_pc",
                       cv(2'd0, 2'd0, 1'b1, 3'd0, 0, 1, 0, 1, 0, 1, 0, 4'h6), FULL));
    steps.push_back(mk(32'h10910002, 4'hF, 1'b0, "adds_ne_fail",
                       cv(2'd0, 2'd0, 1'b0, 3'd0, 0, 0, 0, 0, 0, 1, 0, 4'h6), FULL));
    steps.push_back(mk(32'h8A000003, 4'h0, 1'b0, "bhi_skip",
                       cv(2'd1, 2'd2, 1'b1, 3'd0, 0, 0, 0, 0, 0, 1, 0, 4'h6), FULL));
    foreach (steps[i]) begin
      applyStimulus(steps[i]);
      @(negedge clk);
      e   = sb.pop_front();
      act = actualVec();
      checks++;
      if ((act & e.mask) !== (e.exp & e.mask)) begin
        fails++;
        $display("[TB] FAIL %s: got %05h expected %05h", e.tag, act & e.mask, e.exp & e.mask);
      end
    end
  endtask

`ifdef CTRL_MEMWAIT_EN
  task automatic test_mem_wait();
    stim_t steps[$];
    exp_t  e;
    logic [18:0] act;
    steps.push_back(mk(32'hE5912004, 4'h0, 1'b1, "ldr_zero_wait",
                       cv(2'd0, 2'd1, 1'b1, 3'd0, 1, 1, 0, 0, 1, 1, 0, 4'h6), FULL));
    steps.push_back(mk(32'hE5812000, 4'h0, 1'b1, "str_zero_wait",
                       cv(2'd2, 2'd1, 1'b1, 3'd0, 0, 0, 1, 0, 1, 1, 0, 4'h6), FULL));
    steps.push_back(mk(32'h15812000, 4'h0, 1'b0, "str_ne_fail",
                       cv(2'd2, 2'd1, 1'b1, 3'd0, 0, 0, 0, 0, 0, 1, 0, 4'h6), FULL));
    for (int i = 0; i < 3; i++) begin
      steps.push_back(mk(32'hE5912004, 4'h0, 1'b0, $sformatf("ldr_stall%0d", i),
                         cv(2'd0, 2'd1, 1'b1, 3'd0, 1, 0, 0, 0, 1, 0, 0, 4'h6), FULL));
    end
    steps.push_back(mk(32'hE5912004, 4'h0, 1'b1, "ldr_done",
                       cv(2'd0, 2'd1, 1'b1, 3'd0, 1, 1, 0, 0, 1, 1, 0, 4'h6), FULL));
    steps.push_back(mk(32'hE0810002, 4'h0, 1'b0, "add_after_ldr",
                       cv(2'd0, 2'd0, 1'b0, 3'd0, 0, 1, 0, 0, 0, 1, 0, 4'h6), FULL));
    foreach (steps[i]) begin
      applyStimulus(steps[i]);
      @(negedge clk);
      e   = sb.pop_front();
      act = actualVec();
      checks++;
      if ((act & e.mask) !== (e.exp & e.mask)) begin
        fails++;
        $display("[TB] FAIL %s: got %05h expected %05h", e.tag, act & e.mask, e.exp & e.mask);
      end
    end
  endtask

  task automatic test_reset_midwait();
    stim_t steps[$];
    exp_t  e;
    logic [18:0] act;
    steps.push_back(mk(32'hE5912004, 4'h0, 1'b0, "mid_stall0",
                       cv(2'd0, 2'd1, 1'b1, 3'd0, 1, 0, 0, 0, 1, 0, 0, 4'h6), FULL));
    steps.push_back(mk(32'hE5912004, 4'h0, 1'b0, "mid_stall1",
                       cv(2'd0, 2'd1, 1'b1, 3'd0, 1, 0, 0, 0, 1, 0, 0, 4'h6), FULL));
    foreach (steps[i]) begin
      applyStimulus(steps[i]);
      @(negedge clk);
      e   = sb.pop_front();
      act = actualVec();
      checks++;
      if ((act & e.mask) !== (e.exp & e.mask)) begin
        fails++;
        $display("[TB] FAIL %s: got %05h expected %05h", e.tag, act & e.mask, e.exp & e.mask);
      end
    end
    #1;
    reset = 1'b1;
    e.tag  = "mid_reset";
    e.exp  = cv(2'd0, 2'd1, 1'b1, 3'd0, 1, 0, 0, 0, 0, 0, 0, 4'h0);
    e.mask = FULL;
    sb.push_back(e);
    #1;
    e   = sb.pop_front();
    act = actualVec();
    checks++;
    if ((act & e.mask) !== (e.exp & e.mask)) begin
      fails++;
      $display("[TB] FAIL %s: got %05h expected %05h", e.tag, act & e.mask, e.exp & e.mask);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_timeout();
    stim_t steps[$];
    exp_t  e;
    logic [18:0] act;
    for (int i = 0; i < 15; i++) begin
      steps.push_back(mk(32'hE5812000, 4'h0, 1'b0, $sformatf("str_wait%0d", i),
                         cv(2'd2, 2'd1, 1'b1, 3'd0, 0, 0, 1, 0, 1, 0, 0, 4'h0), FULL));
    end
    steps.push_back(mk(32'hE5812000, 4'h0, 1'b0, "str_timeout",
                       cv(2'd2, 2'd1, 1'b1, 3'd0, 0, 0, 0, 0, 0, 1, 1, 4'h0), NOMEMRQ));
    steps.push_back(mk(32'hE0810002, 4'h0, 1'b0, "fault_one_pulse",
                       cv(2'd0, 2'd0, 1'b0, 3'd0, 0, 1, 0, 0, 0, 1, 0, 4'h0), FULL));
    foreach (steps[i]) begin
      applyStimulus(steps[i]);
      @(negedge clk);
      e   = sb.pop_front();
      act = actualVec();
      checks++;
      if ((act & e.mask) !== (e.exp & e.mask)) begin
        fails++;
        $display("[TB] FAIL %s: got %05h expected %05h", e.tag, act & e.mask, e.exp & e.mask);
      end
    end
  endtask
`else
  task automatic test_single_cycle_mem();
    stim_t steps[$];
    exp_t  e;
    logic [18:0] act;
    steps.push_back(mk(32'hE5912004, 4'h0, 1'b0, "ldr_single",
                       cv(2'd0, 2'd1, 1'b1, 3'd0, 1, 1, 0, 0, 1, 1, 0, 4'h6), FULL));
    steps.push_back(mk(32'hE5812000, 4'h0, 1'b0, "str_single",
                       cv(2'd2, 2'd1, 1'b1, 3'd0, 0, 0, 1, 0, 1, 1, 0, 4'h6), FULL));
    steps.push_back(mk(32'h15812000, 4'h0, 1'b0, "str_ne_fail",
                       cv(2'd2, 2'd1, 1'b1, 3'd0, 0, 0, 0, 0, 0, 1, 0, 4'h6), FULL));
    foreach (steps[i]) begin
      applyStimulus(steps[i]);
      @(negedge clk);
      e   = sb.pop_front();
      act = actualVec();
      checks++;
      if ((act & e.mask) !== (e.exp & e.mask)) begin
        fails++;
        $display("[TB] FAIL %s: got %05h expected %05h", e.tag, act & e.mask, e.exp & e.mask);
      end
    end
    bus.Instr = 32'hE5912004;
    #1;
    reset = 1'b1;
    e.tag  = "reset_during_ldr";
    e.exp  = cv(2'd0, 2'd1, 1'b1, 3'd0, 1, 0, 0, 0, 0, 0, 0, 4'h0);
    e.mask = FULL;
    sb.push_back(e);
    #1;
    e   = sb.pop_front();
    act = actualVec();
    checks++;
    if ((act & e.mask) !== (e.exp & e.mask)) begin
      fails++;
      $display("[TB] FAIL %s: got %05h expected %05h", e.tag, act & e.mask, e.exp & e.mask);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask
`endif

  task automatic test_back_to_back();
    stim_t steps[$];
    exp_t  e;
    logic [18:0] act;
    steps.push_back(mk(32'hE0810002, 4'h0, 1'b1, "b2b_add",
                       cv(2'd0, 2'd0, 1'b0, 3'd0, 0, 1, 0, 0, 0, 1, 0, 4'h0), FULL));
    steps.push_back(mk(32'hE5912004, 4'h0, 1'b1, "b2b_ldr",
                       cv(2'd0, 2'd1, 1'b1, 3'd0, 1, 1, 0, 0, 1, 1, 0, 4'h0), FULL));
    steps.push_back(mk(32'hE5812000, 4'h0, 1'b1, "b2b_str",
                       cv(2'd2, 2'd1, 1'b1, 3'd0, 0, 0, 1, 0, 1, 1, 0, 4'h0), FULL));
    foreach (steps[i]) begin
      applyStimulus(steps[i]);
      @(negedge clk);
      e   = sb.pop_front();
      act = actualVec();
      checks++;
      if ((act & e.mask) !== (e.exp & e.mask)) begin
        fails++;
        $display("[TB] FAIL %s: got %05h expected %05h", e.tag, act & e.mask, e.exp & e.mask);
      end
    end
  endtask

  initial begin
    checks       = 0;
    fails        = 0;
    reset        = 1'b1;
    bus.Instr    = 32'hE0810002;
    bus.ALUFlags = 4'h0;
    bus.MemReady = 1'b0;
    test_reset();
    test_decode_flags();
`ifdef CTRL_MEMWAIT_EN
    test_mem_wait();
    test_reset_midwait();
    test_timeout();
`else
    test_single_cycle_mem();
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
